rtc_init_sequencer: RTL and testbench
=====================================

# rtc_init_sequencer

Sequencer that drives the power-up initialization of the RTC over the shared parallel bus. On `start` it requests the bus, then issues a fixed list of register-write transactions, each a 36-cycle frame with an address-phase strobe and a data-phase strobe. It presents the address/data pair for each command, then signals `done`. It sits between the top-level control FSM (`start`/`done`), the bus arbiter (`req`/`grant`) and the bus driver (`ph1`, `ph2`, `addr_out`, `data_out`).

## Interface

Parameters:
- `NUM_CMDS`, default 4: number of init commands issued; 1..4, entries taken from the table in Operation.
- `GAP_CYCLES`, default 2: idle cycles between frames; 1..7.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: level; sampled only in IDLE.
- `grant` in 1: bus grant from the arbiter; sampled only in REQ.
- `req` out 1: bus request.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the last frame completes.
- `ph1` out 1: address-phase strobe.
- `ph2` out 1: data-phase strobe.
- `addr_out` out 8: register address of the current command.
- `data_out` out 8: write data of the current command.
- `cmd_idx` out 2: index of the current command.

## Operation

- Command table (index: addr, data):
  - 0: 0x02, 0x10 (initialize bit set)
  - 1: 0x02, 0x00 (initialize bit clear)
  - 2: 0x10, 0xD2 (timer config)
  - 3: 0xF2, 0x00 (timer clear)
- States:
  - IDLE -> REQ when `start`=1.
  - REQ -> XFER when `grant`=1.
  - XFER -> GAP at frame count 35 if `cmd_idx` < NUM_CMDS-1; otherwise XFER -> DONE.
  - GAP -> XFER after GAP_CYCLES cycles, with `cmd_idx` incremented on entry to that XFER.
  - DONE -> IDLE unconditionally.
- The 6-bit frame counter runs 0..35 in XFER and clears on XFER entry.
- Strobe windows within a frame:
  - `ph1`=1 for count 0..10; 0 for count 11..35.
  - `ph2`=1 for count 23..34; 0 for count 0..22 and at count 35.
  - `ph1` and `ph2` are never high together. Both are 0 outside XFER.
- `addr_out`/`data_out` hold the table entry for `cmd_idx` during XFER and GAP; 0x00 in IDLE, REQ and DONE.
- `req`=1 in REQ, XFER, GAP; 0 in IDLE and DONE. The bus is held for the whole sequence.
- `grant` deassertion after REQ is ignored; the arbiter must not revoke mid-sequence.
- `start` while `busy` is ignored. `start` held high across DONE relaunches the sequence from IDLE on the following edge.
- All outputs are driven from registers; no combinational path from any input to any output.
- Reset (any time, including mid-frame):
  - All outputs go to 0 immediately.
  - State returns to IDLE.
  - `cmd_idx`, the frame counter and the gap counter clear to 0.
  - No partial frame resumes after reset release.

## Timing

- The edge that samples `start`=1 in IDLE is edge E0. REQ is occupied from E0.
- With `grant`=1 at E1, XFER frame 0 (count 0) is the cycle after E1.
- Each frame lasts exactly 36 cycles; each gap lasts exactly GAP_CYCLES cycles.
- `done` is high for one cycle, 1 + NUM_CMDS*36 + (NUM_CMDS-1)*GAP_CYCLES cycles after E0. Defaults: 151 cycles, i.e. `done` is high in the cycle starting at edge E0+151.
- `busy` falls in the cycle after `done`.
- Each cycle of `grant` delay in REQ adds one cycle to this latency.

## Test plan

- Reset: assert `reset`=0 mid-run (frame 1, count 15). All outputs read 0 immediately. After release with `start`=0, the block stays in IDLE with `req`=0.
- Full sequence, defaults, `grant` tied 1, one-cycle `start` pulse:
  - Exactly 4 `ph1` pulses of 11 cycles and 4 `ph2` pulses of 12 cycles.
  - `addr_out`/`data_out` step through 02/10, 02/00, 10/D2, F2/00.
  - 2-cycle strobe-free gaps between frames.
  - `done` 151 cycles after E0.
- Delayed grant: hold `grant`=0 for 20 cycles after `start`. `req`=1 and no strobes until grant; `done` arrives 20 cycles later than in the previous scenario.
- Start while busy: pulse `start` during frame 2. No restart occurs, `cmd_idx` continues 2 -> 3, and exactly one `done` is produced.
- Parameters NUM_CMDS=1, GAP_CYCLES=5: a single frame (02/10) is issued, and `done` is high 37 cycles after E0.
- `start` held high continuously: back-to-back sequences, with `busy` low for exactly one cycle (IDLE) between `done` and the next REQ.

Source files
------------

// File: rtl/rtc_init_sequencer.sv
// rtc_init_sequencer: issues the fixed RTC power-up register writes over the
// shared parallel bus. Requests the bus on start, then runs one 36-cycle frame
// per command (ph1 address strobe, ph2 data strobe) separated by idle gaps,
// and pulses done after the last frame.
//
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-low reset
//   start     - launch request, sampled only in IDLE
//   grant     - bus grant, sampled only in REQ
//   req       - bus request, held from REQ through the last gap/frame
//   busy      - high in every state but IDLE
//   done      - one-cycle pulse after the last frame
//   ph1, ph2  - address-phase / data-phase strobes
//   addr_out  - register address of the current command
//   data_out  - write data of the current command
//   cmd_idx   - index of the current command
module rtc_init_sequencer #(
    parameter int unsigned NUM_CMDS   = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       grant,
    output logic       req,
    output logic       busy,
    output logic       done,
    output logic       ph1,
    output logic       ph2,
    output logic [7:0] addr_out,
    output logic [7:0] data_out,
    output logic [1:0] cmd_idx
);

    localparam int unsigned FRAME_W = 6;
    localparam int unsigned GAP_W   = 3;
    localparam int unsigned IDX_W   = 2;

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(35);
    localparam logic [FRAME_W-1:0] PH1_LAST   = FRAME_W'(10);
    localparam logic [FRAME_W-1:0] PH2_FIRST  = FRAME_W'(23);
    localparam logic [FRAME_W-1:0] PH2_LAST   = FRAME_W'(34);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_CMDS - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_GAP,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic       req_q, req_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ph1_q, ph1_d;
    logic       ph2_q, ph2_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;

    // Init command table: {addr, data}
    function automatic logic [15:0] cmd_entry(input logic [IDX_W-1:0] idx);
        case (idx)
            2'd0:    return 16'h0210;
            2'd1:    return 16'h0200;
            2'd2:    return 16'h10D2;
            default: return 16'hF200;
        endcase
    endfunction

    // State, counter and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            gap_cnt_q   <= '0;
            idx_q       <= '0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ph1_q       <= 1'b0;
            ph2_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            idx_q       <= idx_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ph1_q       <= ph1_d;
            ph2_q       <= ph2_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    // Next state and counters
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        idx_d       = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_REQ;
                    idx_d       = '0;
                    frame_cnt_d = '0;
                    gap_cnt_d   = '0;
                end
            end
            S_REQ: begin
                if (grant) begin
                    state_d     = S_XFER;
                    frame_cnt_d = '0;
                end
            end
            S_XFER: begin
                if (frame_cnt_q == FRAME_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = (idx_q < IDX_LAST) ? S_GAP : S_DONE;
                end else begin
                    frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d     = S_XFER;
                    frame_cnt_d = '0;
                    idx_d       = idx_q + IDX_W'(1);
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so the registered copies line up with the state
    always_comb begin
        req_d  = 1'b0;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        ph1_d  = 1'b0;
        ph2_d  = 1'b0;
        addr_d = '0;
        data_d = '0;
        if (state_d == S_REQ || state_d == S_XFER || state_d == S_GAP) begin
            req_d = 1'b1;
        end
        if (state_d == S_XFER || state_d == S_GAP) begin
            {addr_d, data_d} = cmd_entry(idx_d);
        end
        if (state_d == S_XFER) begin
            ph1_d = (frame_cnt_d <= PH1_LAST);
            ph2_d = (frame_cnt_d >= PH2_FIRST) && (frame_cnt_d <= PH2_LAST);
        end
    end

    assign req      = req_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ph1      = ph1_q;
    assign ph2      = ph2_q;
    assign addr_out = addr_q;
    assign data_out = data_q;
    assign cmd_idx  = idx_q;

endmodule

// File: tb/tb_rtc_init_sequencer.sv
// Bench for rtc_init_sequencer: a default instance and a NUM_CMDS=1/GAP_CYCLES=5
// instance share the inputs; each is compared every cycle against a timeline model
// that derives frame, position and strobes from elapsed cycles since grant.
module tb_rtc_init_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       grant;
    logic [1:0] req_w, busy_w, done_w, ph1_w, ph2_w;
    logic [7:0] addr_w [2];
    logic [7:0] data_w [2];
    logic [1:0] idx_w  [2];

    rtc_init_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .grant(grant),
        .req(req_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .ph1(ph1_w[0]), .ph2(ph2_w[0]),
        .addr_out(addr_w[0]), .data_out(data_w[0]), .cmd_idx(idx_w[0])
    );

    rtc_init_sequencer #(.NUM_CMDS(1), .GAP_CYCLES(5)) dut1 (
        .clk(clk), .reset(reset), .start(start), .grant(grant),
        .req(req_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .ph1(ph1_w[1]), .ph2(ph2_w[1]),
        .addr_out(addr_w[1]), .data_out(data_w[1]), .cmd_idx(idx_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference: 0 idle, 1 waiting for grant, 2 running (t cycles since frame 0), 3 done
    int m_ph [2];
    int m_t  [2];
    int mn   [2];
    int mg   [2];
    logic [7:0] t_addr [4];
    logic [7:0] t_data [4];

    int done_cnt [2];
    int first_done [2];
    int ph1_hi [2];
    int ph2_hi [2];
    int ph1_rise [2];
    int ph2_rise [2];
    logic [1:0] prev_ph1, prev_ph2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int seq_len(input int i);
        return mn[i] * 36 + (mn[i] - 1) * mg[i];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0;
            m_t[i]  = 0;
        end
    endfunction

    function automatic void model_step(input int i, input logic st, input logic gr);
        case (m_ph[i])
            0: if (st) m_ph[i] = 1;
            1: if (gr) begin m_ph[i] = 2; m_t[i] = 0; end
            2: begin
                m_t[i] = m_t[i] + 1;
                if (m_t[i] == seq_len(i)) m_ph[i] = 3;
            end
            default: m_ph[i] = 0;
        endcase
    endfunction

    // Expected {req,busy,done,ph1,ph2}, addr, data, index (index valid only while running)
    function automatic void model_expect(input int i, output logic [4:0] ctl,
                                         output logic [7:0] a, output logic [7:0] d,
                                         output logic [1:0] idx, output bit run);
        int per, f, p;
        bit x;
        ctl = '0; a = '0; d = '0; idx = '0; run = 1'b0;
        case (m_ph[i])
            1: ctl = 5'b11000;
            2: begin
                per = 36 + mg[i];
                f   = m_t[i] / per;
                p   = m_t[i] % per;
                x   = (p < 36);
                run = 1'b1;
                ctl = {1'b1, 1'b1, 1'b0, x && (p <= 10), x && (p >= 23) && (p <= 34)};
                a   = t_addr[f];
                d   = t_data[f];
                idx = 2'(f);
            end
            3: ctl = 5'b01100;
            default: ctl = '0;
        endcase
    endfunction

    function automatic logic [4:0] dut_ctl(input int i);
        return {req_w[i], busy_w[i], done_w[i], ph1_w[i], ph2_w[i]};
    endfunction

    task automatic compare_all();
        logic [4:0] ectl;
        logic [7:0] ea, ed;
        logic [1:0] eidx;
        bit run;
        for (int i = 0; i < 2; i++) begin
            model_expect(i, ectl, ea, ed, eidx, run);
            chk($sformatf("ctl[%0d]", i), 32'(dut_ctl(i)), 32'(ectl));
            chk($sformatf("addr[%0d]", i), 32'(addr_w[i]), 32'(ea));
            chk($sformatf("data[%0d]", i), 32'(data_w[i]), 32'(ed));
            if (run) chk($sformatf("cmd_idx[%0d]", i), 32'(idx_w[i]), 32'(eidx));
        end
    endtask

    task automatic reset_stats();
        for (int i = 0; i < 2; i++) begin
            done_cnt[i] = 0; first_done[i] = -1;
            ph1_hi[i] = 0; ph2_hi[i] = 0; ph1_rise[i] = 0; ph2_rise[i] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) model_step(i, start, grant);
        #1;
        compare_all();
        for (int i = 0; i < 2; i++) begin
            if (done_w[i]) begin
                done_cnt[i]++;
                if (first_done[i] < 0) first_done[i] = cyc;
            end
            if (ph1_w[i]) ph1_hi[i]++;
            if (ph2_w[i]) ph2_hi[i]++;
            if (ph1_w[i] && !prev_ph1[i]) ph1_rise[i]++;
            if (ph2_w[i] && !prev_ph2[i]) ph2_rise[i]++;
        end
        prev_ph1 = ph1_w;
        prev_ph2 = ph2_w;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_ctl[%0d]", tag, i), 32'(dut_ctl(i)), 32'd0);
            chk($sformatf("%s_addr[%0d]", tag, i), 32'(addr_w[i]), 32'd0);
            chk($sformatf("%s_data[%0d]", tag, i), 32'(data_w[i]), 32'd0);
            chk($sformatf("%s_idx[%0d]", tag, i), 32'(idx_w[i]), 32'd0);
        end
    endtask

    // Async reset pulse mid-cycle; called right after tick (posedge+1)
    task automatic async_reset_pulse(input string tag);
        #2 reset = 1'b0;
        #1 check_all_zero(tag);
        model_reset();
        #2 reset = 1'b1;
    endtask

    task automatic wait_done0(input int budget);
        for (int k = 0; k < budget && done_cnt[0] == 0; k++) tick();
    endtask

    initial begin
        int c0, cnt;
        mn[0] = 4; mg[0] = 2;
        mn[1] = 1; mg[1] = 5;
        t_addr[0] = 8'h02; t_data[0] = 8'h10;
        t_addr[1] = 8'h02; t_data[1] = 8'h00;
        t_addr[2] = 8'h10; t_data[2] = 8'hD2;
        t_addr[3] = 8'hF2; t_data[3] = 8'h00;
        model_reset();
        reset_stats();
        prev_ph1 = '0; prev_ph2 = '0;
        reset = 1'b0; start = 1'b0; grant = 1'b0;

        #12 check_all_zero("por");
        #1 reset = 1'b1;
        tick(); tick();

        // Full sequence, grant tied high, one-cycle start pulse
        grant = 1'b1;
        reset_stats();
        start = 1'b1; tick(); c0 = cyc; start = 1'b0;
        wait_done0(300);
        chk("lat_full", 32'(first_done[0] - c0), 32'd151);
        chk("lat_full_n1", 32'(first_done[1] - c0), 32'd37);
        repeat (4) tick();
        chk("ph1_pulses", 32'(ph1_rise[0]), 32'd4);
        chk("ph1_cycles", 32'(ph1_hi[0]), 32'd44);
        chk("ph2_pulses", 32'(ph2_rise[0]), 32'd4);
        chk("ph2_cycles", 32'(ph2_hi[0]), 32'd48);
        chk("ph1_cycles_n1", 32'(ph1_hi[1]), 32'd11);
        chk("ph2_cycles_n1", 32'(ph2_hi[1]), 32'd12);
        chk("idle_busy", 32'(busy_w), 32'd0);

        // Grant withheld for 20 cycles after start
        reset_stats();
        grant = 1'b0;
        start = 1'b1; tick(); c0 = cyc; start = 1'b0;
        repeat (20) tick();
        chk("req_wait", 32'(req_w), 32'b11);
        grant = 1'b1;
        wait_done0(300);
        chk("lat_delay", 32'(first_done[0] - c0), 32'd171);
        chk("lat_delay_n1", 32'(first_done[1] - c0), 32'd57);
        repeat (4) tick();

        // start pulsed during frame 2 must be ignored
        reset_stats();
        start = 1'b1; tick(); c0 = cyc; start = 1'b0;
        repeat (82) tick();
        chk("busy_mid_idx", 32'(idx_w[0]), 32'd2);
        start = 1'b1; tick(); start = 1'b0;
        wait_done0(300);
        chk("lat_busy_start", 32'(first_done[0] - c0), 32'd151);
        repeat (10) tick();
        chk("done_pulses", 32'(done_cnt[0]), 32'd1);

        // Reset in frame 1, count 15
        repeat (60) tick();
        reset_stats();
        start = 1'b1; tick(); start = 1'b0;
        repeat (54) tick();
        chk("pre_rst_idx", 32'(idx_w[0]), 32'd1);
        chk("pre_rst_ph", 32'({ph1_w[0], ph2_w[0]}), 32'd0);
        async_reset_pulse("rst");
        repeat (5) tick();
        chk("post_rst_req", 32'(req_w), 32'd0);
        chk("post_rst_busy", 32'(busy_w), 32'd0);

        // start held high: back-to-back runs with exactly one IDLE cycle between
        reset_stats();
        start = 1'b1;
        wait_done0(300);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!busy_w[0]) cnt++;
            else if (cnt > 0) break;
        end
        chk("b2b_idle_cycles", 32'(cnt), 32'd1);
        chk("b2b_relaunch_req", 32'(req_w[0]), 32'd1);
        start = 1'b0;
        repeat (200) tick();

        // Randomized start/grant with occasional async reset
        for (int k = 0; k < 3000; k++) begin
            start = ($urandom_range(0, 15) == 0);
            grant = 1'($urandom_range(0, 1));
            tick();
            if ($urandom_range(0, 599) == 0) async_reset_pulse("rnd_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
